tiny_core_sequencer: RTL and testbench

//  Parametrised multi-cycle successor of the TinyChip single-cycle controller.

---
 rtl/tiny_core_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_tiny_core_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_core_sequencer.sv
// Multi-cycle 9-bit-ISA sequencer: fetches over imem req/ack, executes against a
// 4-entry register file, and performs loads/stores over dmem req/ack.
module tiny_core_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RST_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [8:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              instr_done,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   dbg_pc
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [8:0]             ir_q, ir_d;
  logic [3:0][DATA_W-1:0] rf_q;
  logic [DATA_W-1:0]      daddr_q, daddr_d, dwdata_q, dwdata_d, ld_q, ld_d;
  logic                   dwe_q, dwe_d;
  logic                   rf_we;
  logic [DATA_W-1:0]      rf_wd;

  logic        is_i, fn;
  logic [2:0]  op, imm;
  logic [1:0]  rd, rs;
  assign is_i = ir_q[8];
  assign op   = ir_q[7:5];
  assign rd   = ir_q[4:3];
  assign imm  = ir_q[2:0];
  assign rs   = ir_q[2:1];
  assign fn   = ir_q[0];

  logic [DATA_W-1:0] a, b, imm_z, alu_res;
  assign a     = rf_q[rd];
  assign b     = rf_q[rs];
  assign imm_z = DATA_W'(imm);

  logic is_mem, is_br, is_sys, br_taken;
  assign is_mem   = is_i && (op[2:1] == 2'b10);
  assign is_br    = is_i && (op[2:1] == 2'b01);
  assign is_sys   = !is_i && (op == 3'b111);
  assign br_taken = (a == rf_q[0]) ^ op[0];

  logic [PC_W-1:0] pc_inc, br_tgt, jr_tgt;
  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_q + PC_W'($signed(imm));

  generate
    if (PC_W <= DATA_W) begin : g_jr_trunc
      assign jr_tgt = b[PC_W-1:0];
    end else begin : g_jr_pad
      assign jr_tgt = {{(PC_W-DATA_W){1'b0}}, b};
    end
  endgenerate

  // R-type ops combine R[rd] with R[rs]; slt sets when R[rs] < R[rd] (signed).
  always_comb begin
    alu_res = '0;
    if (is_i) begin
      case (op)
        3'b000:  alu_res = a + imm_z;
        3'b001:  alu_res = a & imm_z;
        3'b110:  alu_res = a >> imm;
        3'b111:  alu_res = DATA_W'($signed(a) < $signed(imm_z));
        default: alu_res = '0;
      endcase
    end else begin
      case (op)
        3'b000:  alu_res = a + b;
        3'b001:  alu_res = a - b;
        3'b010:  alu_res = a & b;
        3'b011:  alu_res = a | b;
        3'b100:  alu_res = a ^ b;
        3'b101:  alu_res = a << b[2:0];
        3'b110:  alu_res = DATA_W'($signed(b) < $signed(a));
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    dwe_d      = dwe_q;
    ld_d       = ld_q;
    rf_we      = 1'b0;
    rf_wd      = alu_res;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d    = S_FETCH;
        instr_done = 1'b1;
        pc_d       = pc_inc;
        if (is_mem) begin
          instr_done = 1'b0;
          pc_d       = pc_q;
          state_d    = S_MEM;
          daddr_d    = rf_q[imm[1:0]];
          dwdata_d   = a;
          dwe_d      = op[0];
        end else if (is_sys && fn) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end else if (is_sys) begin
          pc_d = jr_tgt;
        end else if (is_br) begin
          pc_d = br_taken ? br_tgt : pc_inc;
        end else begin
          rf_we = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (dwe_q) begin
            instr_done = 1'b1;
            pc_d       = pc_inc;
            state_d    = S_FETCH;
          end else begin
            ld_d    = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_wd      = ld_q;
        pc_d       = pc_inc;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(RST_PC);
      ir_q     <= '0;
      rf_q     <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwe_q    <= 1'b0;
      ld_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dwe_q    <= dwe_d;
      ld_q     <= ld_d;
      if (rf_we) rf_q[rd] <= rf_wd;
    end
  end

  assign imem_addr  = pc_q;
  assign dbg_pc     = pc_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_we    = dwe_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_tiny_core_sequencer.sv
// Directed bench for tiny_core_sequencer: small programs run against a ROM and a
// latency-programmable data memory; results checked through stores and status pins.
module tb_tiny_core_sequencer;

  logic       clk, reset, start;
  logic       imem_req, imem_ack;
  logic [7:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic       instr_done, busy, halted;
  logic [7:0] dbg_pc;

  tiny_core_sequencer #(.DATA_W(8), .PC_W(8), .RST_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .instr_done(instr_done), .busy(busy), .halted(halted), .dbg_pc(dbg_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] rom   [256];
  logic [7:0] dmem  [256];
  logic [7:0] dinit [256];
  logic       dload, dmem_en, force_ack;
  int         dmem_lat, dwait;
  int         ndone = 0;
  int         total = 0;
  int         passed = 0;

  assign imem_ack   = imem_req;
  assign imem_rdata = rom[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = force_ack | (dmem_req & dmem_en & (dwait >= dmem_lat));

  always @(posedge clk) begin
    if (dload) dmem <= dinit;
    else if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (dmem_req && !dmem_ack) dwait <= dwait + 1;
    else dwait <= 0;
    if (instr_done) ndone <= ndone + 1;
  end

  function automatic logic [8:0] iI(input logic [2:0] op, input logic [1:0] rd, input logic [2:0] imm);
    return {1'b1, op, rd, imm};
  endfunction
  function automatic logic [8:0] iR(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic fn);
    return {1'b0, op, rd, rs, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]   = iR(3'b111, 2'd0, 2'd0, 1'b1);
      dinit[i] = 8'hAA;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; dload = 1'b1;
    @(negedge clk);
    dload = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_done && n < 40);
  endtask

  task automatic run_halt();
    int n;
    n = 0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, base, reqs, w, bad;
    logic [7:0] sa, sd;
    reset = 1'b1; start = 1'b0; dload = 1'b0; dmem_en = 1'b1; force_ack = 1'b0; dmem_lat = 0;

    // 1: two addi, a store and halt; then start is ignored in HALT
    clear_mem();
    rom[0] = iI(3'b000, 2'd1, 3'd5);
    rom[1] = iI(3'b000, 2'd1, 3'd3);
    rom[2] = iI(3'b101, 2'd1, 3'd0);
    rom[3] = iR(3'b111, 2'd0, 2'd0, 1'b1);
    do_reset();
    reset = 1'b0;
    #2;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_done", instr_done, 0);
    check("rst_pc", dbg_pc, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    base = ndone;
    go();
    wait_done(n); check("addi1_lat", n, 2);
    wait_done(n); check("addi2_lat", n, 2);
    settle();
    check("pc_after2", dbg_pc, 2);
    check("done_count2", ndone - base, 2);
    check("busy_run", busy, 1);
    wait_done(n); check("sw_lat", n, 3);
    check("sw_addr", dmem_addr, 0);
    check("sw_wdata", dmem_wdata, 8);
    check("sw_we", dmem_we, 1);
    settle();
    check("mem0_eq8", dmem[0], 8);
    wait_done(n); check("halt_lat", n, 2);
    settle();
    check("halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", dbg_pc, 3);
    start = 1'b1;
    reqs = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    start = 1'b0;
    check("halt_no_fetch", reqs, 0);
    check("halt_stays", halted, 1);

    // 2: lw latency, wrap on addi, signed slt both ways
    clear_mem();
    dinit[0] = 8'hFF; dinit[1] = 8'h80;
    rom[0]  = iI(3'b100, 2'd1, 3'd0);
    rom[1]  = iI(3'b000, 2'd1, 3'd1);
    rom[2]  = iI(3'b000, 2'd3, 3'd2);
    rom[3]  = iI(3'b101, 2'd1, 3'd3);
    rom[4]  = iI(3'b000, 2'd2, 3'd1);
    rom[5]  = iI(3'b000, 2'd0, 3'd1);
    rom[6]  = iI(3'b100, 2'd1, 3'd0);
    rom[7]  = iR(3'b110, 2'd2, 2'd1, 1'b0);
    rom[8]  = iI(3'b000, 2'd3, 3'd1);
    rom[9]  = iI(3'b101, 2'd2, 3'd3);
    rom[10] = iR(3'b110, 2'd1, 2'd2, 1'b0);
    rom[11] = iI(3'b000, 2'd3, 3'd1);
    rom[12] = iI(3'b101, 2'd1, 3'd3);
    rom[13] = iR(3'b111, 2'd0, 2'd0, 1'b1);
    do_reset();
    base = ndone;
    go();
    wait_done(n); check("lw_lat", n, 4);
    run_halt();
    check("addi_wrap", dmem[2], 8'h00);
    check("slt_neg_lt", dmem[3], 8'h01);
    check("slt_pos_nlt", dmem[4], 8'h00);
    check("done_count14", ndone - base, 14);

    // 3: delayed dmem ack holds the request stable; ALU mix
    clear_mem();
    rom[0]  = iI(3'b000, 2'd2, 3'd6);
    rom[1]  = iI(3'b000, 2'd1, 3'd5);
    rom[2]  = iI(3'b101, 2'd1, 3'd2);
    rom[3]  = iI(3'b100, 2'd3, 3'd2);
    rom[4]  = iI(3'b101, 2'd3, 3'd0);
    rom[5]  = iR(3'b001, 2'd1, 2'd2, 1'b0);
    rom[6]  = iR(3'b100, 2'd3, 2'd2, 1'b0);
    rom[7]  = iR(3'b101, 2'd2, 2'd3, 1'b0);
    rom[8]  = iI(3'b110, 2'd1, 3'd4);
    rom[9]  = iI(3'b001, 2'd1, 3'd6);
    rom[10] = iR(3'b011, 2'd3, 2'd2, 1'b0);
    rom[11] = iR(3'b010, 2'd3, 2'd1, 1'b0);
    rom[12] = iI(3'b111, 2'd1, 3'd7);
    rom[13] = iR(3'b000, 2'd3, 2'd1, 1'b0);
    rom[14] = iI(3'b000, 2'd0, 3'd7);
    rom[15] = iI(3'b101, 2'd3, 3'd0);
    rom[16] = iI(3'b101, 2'd2, 3'd2);
    rom[17] = iI(3'b101, 2'd1, 3'd1);
    rom[18] = iR(3'b111, 2'd0, 2'd0, 1'b1);
    dmem_lat = 3;
    do_reset();
    base = ndone;
    go();
    n = 0;
    while (!dmem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("dreq_seen", dmem_req, 1);
    check("dly_addr", dmem_addr, 6);
    check("dly_wdata", dmem_wdata, 5);
    check("dly_we", dmem_we, 1);
    sa = dmem_addr; sd = dmem_wdata;
    w = 0; bad = 0;
    while (!dmem_ack && w < 20) begin
      @(negedge clk);
      w++;
      if (!dmem_req || dmem_addr !== sa || dmem_wdata !== sd || dmem_we !== 1'b1) bad++;
    end
    check("dly_wait", w, 3);
    check("dly_stable", bad, 0);
    check("dly_sw_retire", instr_done, 1);
    run_halt();
    check("sw_delayed", dmem[6], 5);
    check("lw_delayed", dmem[0], 5);
    check("alu_chain", dmem[7], 3);
    check("sll_res", dmem[8'h30], 8'h30);
    check("slti_res", dmem[1], 1);
    check("done_count19", ndone - base, 19);
    dmem_lat = 0;

    // 4: branch wrap backwards, not-taken bne, PC+1 wrap, taken bne, jr
    clear_mem();
    rom[8'h00] = iI(3'b010, 2'd1, 3'b110);
    rom[8'h01] = iI(3'b011, 2'd1, 3'b011);
    rom[8'hFE] = iI(3'b011, 2'd0, 3'b011);
    rom[8'hFF] = iI(3'b000, 2'd1, 3'd7);
    rom[8'h03] = iI(3'b101, 2'd1, 3'd2);
    rom[8'h04] = iI(3'b000, 2'd2, 3'd3);
    rom[8'h05] = iR(3'b111, 2'd0, 2'd2, 1'b0);
    rom[8'h06] = iI(3'b101, 2'd2, 3'd2);
    rom[8'h07] = iR(3'b111, 2'd0, 2'd0, 1'b1);
    do_reset();
    go();
    wait_done(n); check("beq_lat", n, 2);
    settle(); check("beq_taken_wrap", dbg_pc, 8'hFE);
    wait_done(n); settle(); check("bne_not_taken", dbg_pc, 8'hFF);
    wait_done(n); settle(); check("pc_inc_wrap", dbg_pc, 8'h00);
    wait_done(n); settle(); check("beq_not_taken", dbg_pc, 8'h01);
    wait_done(n); settle(); check("bne_taken", dbg_pc, 8'h04);
    run_halt();
    check("jr_store1", dmem[3], 7);
    check("jr_store2", dmem[6], 6);
    check("jr_halt_pc", dbg_pc, 7);

    // 6: reset in the middle of a load; late ack ignored; restart at RST_PC
    clear_mem();
    dinit[0] = 8'h5A;
    rom[0] = iI(3'b100, 2'd1, 3'd0);
    rom[1] = iI(3'b000, 2'd2, 3'd1);
    rom[2] = iI(3'b101, 2'd1, 3'd2);
    rom[3] = iR(3'b111, 2'd0, 2'd0, 1'b1);
    do_reset();
    dmem_en = 1'b0;
    go();
    n = 0;
    while (!dmem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_dreq", dmem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_drop_req", dmem_req, 0);
    check("rst_drop_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    base = ndone;
    force_ack = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || instr_done || imem_req) bad++;
    end
    force_ack = 1'b0;
    dmem_en = 1'b1;
    check("late_ack_ignored", bad, 0);
    check("late_ack_pc", dbg_pc, 0);
    go();
    @(negedge clk);
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 0);
    run_halt();
    check("restart_prog", dmem[1], 8'h5A);
    check("restart_count", ndone - base, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
